// File: rtl/pp_bridge_ctrl_pkg.sv
// pp_bridge_ctrl_pkg: shared state type and default sizing for the LP -> Qn*KnT ping-pong bridge.
package pp_bridge_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, RST_MM, RUN, WAIT_ACC, DRAIN, RELEASE, DONE} pp_state_t;
  localparam int QK_BLOCK_SIZE      = 4;
  localparam int QK_INNER_DIMENSION = 16;
  localparam int QK_NUM_CORES       = 8;
  localparam int PP_ROWS_PER_BANK   = QK_BLOCK_SIZE;
  localparam int PP_RD_BEATS        = QK_INNER_DIMENSION / QK_BLOCK_SIZE;
  localparam int PP_NUM_BLOCKS      = QK_NUM_CORES;
endpackage

// File: rtl/pp_bridge_ctrl.sv
// pp_bridge_ctrl: fills one bank from LP while the matmul consumes the other, sequencing matmul reset/enable per pass.
module pp_bridge_ctrl
  import pp_bridge_ctrl_pkg::*;
#(
  parameter int ROWS_PER_BANK = PP_ROWS_PER_BANK,
  parameter int RD_BEATS      = PP_RD_BEATS,
  parameter int NUM_BLOCKS    = PP_NUM_BLOCKS,
  localparam int WA_W = $clog2(ROWS_PER_BANK),
  localparam int RA_W = RD_BEATS > 1 ? $clog2(RD_BEATS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            acc_done_wrap,
  input  logic            systolic_finish_wrap,
  output logic [1:0]      wr_en,
  output logic [WA_W-1:0] wr_addr,
  output logic            rd_bank,
  output logic [RA_W-1:0] rd_addr,
  output logic            internal_rst_n_ctrl,
  output logic            internal_reset_acc_ctrl,
  output logic            enable_matmul,
  output logic            out_valid,
  output logic            done,
  output logic            overflow
);
  localparam int BC_W = NUM_BLOCKS > 1 ? $clog2(NUM_BLOCKS) : 1;
  pp_state_t       r_state;
  logic [1:0]      r_full;
  logic            r_wr_bank;
  logic [BC_W-1:0] r_blk_cnt;
  logic            w_accept;
  logic            w_wr_last;
  logic [1:0]      w_set;
  logic [1:0]      w_clr;
  assign in_ready  = !r_full[r_wr_bank] && !done;
  assign w_accept  = in_valid && in_ready;
  assign wr_en     = w_accept ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_wr_last = wr_addr == WA_W'(ROWS_PER_BANK - 1);
  // set and clear always target different banks, so they can share one edge
  assign w_set     = (w_accept && w_wr_last) ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr     = (r_state == RELEASE) ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      wr_addr   <= '0;
      overflow  <= 1'b0;
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;
      if (w_accept) begin
        wr_addr <= w_wr_last ? '0 : wr_addr + 1'b1;
        if (w_wr_last) r_wr_bank <= !r_wr_bank;
      end
      if (in_valid && !in_ready && !done) overflow <= 1'b1;
    end
  end

  // control outputs are loaded on the transition so they hold for the whole state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state                 <= IDLE;
      rd_bank                 <= 1'b0;
      rd_addr                 <= '0;
      r_blk_cnt               <= '0;
      internal_rst_n_ctrl     <= 1'b0;
      internal_reset_acc_ctrl <= 1'b1;
      enable_matmul           <= 1'b0;
      out_valid               <= 1'b0;
      done                    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          internal_rst_n_ctrl     <= !r_full[rd_bank];
          internal_reset_acc_ctrl <= r_full[rd_bank];
          if (r_full[rd_bank]) begin
            r_state <= RST_MM;
            rd_addr <= '0;
          end
        end
        RST_MM: begin
          r_state                 <= RUN;
          internal_rst_n_ctrl     <= 1'b1;
          internal_reset_acc_ctrl <= 1'b0;
          enable_matmul           <= 1'b1;
        end
        RUN: begin
          if (rd_addr == RA_W'(RD_BEATS - 1)) r_state <= WAIT_ACC;
          else rd_addr <= rd_addr + 1'b1;
        end
        WAIT_ACC: begin
          if (acc_done_wrap) r_state <= systolic_finish_wrap ? RELEASE : DRAIN;
          out_valid     <= acc_done_wrap && systolic_finish_wrap;
          enable_matmul <= !(acc_done_wrap && systolic_finish_wrap);
        end
        DRAIN: begin
          if (systolic_finish_wrap) r_state <= RELEASE;
          out_valid     <= systolic_finish_wrap;
          enable_matmul <= !systolic_finish_wrap;
        end
        RELEASE: begin
          rd_bank   <= !rd_bank;
          r_blk_cnt <= r_blk_cnt + 1'b1;
          r_state   <= (r_blk_cnt == BC_W'(NUM_BLOCKS - 1)) ? DONE : IDLE;
          done      <= r_blk_cnt == BC_W'(NUM_BLOCKS - 1);
        end
        default: r_state <= DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_pp_bridge_ctrl.sv
// tb_pp_bridge_ctrl: directed stimulus with queued expected writes/out_valid pulses checked by a negedge monitor.
module tb_pp_bridge_ctrl;
  localparam int ROWS = 4;
  localparam int RD   = 4;
  localparam int NB   = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic acc_done = 1'b0;
  logic fin = 1'b0;
  logic in_ready, rd_bank, rst_n_ctrl, reset_acc, en, out_valid, done, overflow;
  logic [1:0] wr_en, wr_addr, rd_addr;
  int checks = 0;
  int errors = 0;
  logic [2:0] wr_q[$];
  logic ov_q[$];
  int m_bank = 0;
  int m_addr = 0;
  int total_sent = 0;
  int first_stall = -1;

  pp_bridge_ctrl #(.ROWS_PER_BANK(ROWS), .RD_BEATS(RD), .NUM_BLOCKS(NB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .acc_done_wrap(acc_done), .systolic_finish_wrap(fin),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .internal_rst_n_ctrl(rst_n_ctrl), .internal_reset_acc_ctrl(reset_acc),
    .enable_matmul(en), .out_valid(out_valid), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    if (wr_en != 2'b00) begin
      if (wr_q.size() == 0) chk("wr_unexpected", int'(wr_en), 0);
      else begin
        e = wr_q.pop_front();
        chk("wr_en", int'(wr_en), e[2] ? 2 : 1);
        chk("wr_addr", int'(wr_addr), int'(e[1:0]));
      end
    end
    if (out_valid) begin
      if (ov_q.size() == 0) chk("ov_unexpected", int'(out_valid), 0);
      else chk("ov_bank", int'(rd_bank), int'(ov_q.pop_front()));
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rst_n"}, rst_n_ctrl, 0);
    chk({tag, "_acc_clr"}, reset_acc, 1);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_rd_bank"}, rd_bank, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    acc_done = 1'b0;
    fin = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    m_bank = 0;
    m_addr = 0;
  endtask

  task automatic send_beats(input int n);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 200) begin
      guard++;
      if (in_ready) begin
        wr_q.push_back({m_bank[0], m_addr[1:0]});
        in_valid = 1'b1;
        m_addr++;
        if (m_addr == ROWS) begin
          m_addr = 0;
          m_bank ^= 1;
        end
        sent++;
        total_sent++;
      end else begin
        if (first_stall < 0) first_stall = total_sent;
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    if (sent != n) chk("send_timeout", sent, n);
  endtask

  task automatic wait_en();
    int guard = 0;
    while (!en && guard < 100) begin
      guard++;
      tick();
    end
    if (!en) chk("wait_en_timeout", en, 1);
  endtask

  task automatic responder();
    wait_en();
    repeat (6) tick();
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    repeat (13) tick();
    ov_q.push_back(1'b0);
    fin = 1'b1;
    tick();
    fin = 1'b0;
    chk("t3_ov_pulse", out_valid, 1);
    chk("t3_stalled_in_release", in_ready, 0);
    tick();
    chk("t3_ready_after_release", in_ready, 1);
    chk("t3_rd_bank", rd_bank, 1);
    wait_en();
    repeat (6) tick();
    ov_q.push_back(1'b1);
    acc_done = 1'b1;
    fin = 1'b1;
    tick();
    acc_done = 1'b0;
    fin = 1'b0;
    chk("t4_ov_pulse", out_valid, 1);
    chk("t4_en_release", en, 0);
    tick();
    chk("t4_ov_single", out_valid, 0);
    chk("t5_done", done, 1);
    chk("t5_en", en, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int guard;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk("idle_rst_n", rst_n_ctrl, 1);
    chk("idle_acc_clr", reset_acc, 0);
    // T1: fill bank0, watch enable and read addresses
    send_beats(4);
    chk("t1_en_idle", en, 0);
    chk("t1_in_ready_bank1", in_ready, 1);
    tick();
    chk("t1_rstmm_rst_n", rst_n_ctrl, 0);
    chk("t1_rstmm_acc_clr", reset_acc, 1);
    chk("t1_rstmm_en", en, 0);
    tick();
    chk("t1_run_en", en, 1);
    chk("t1_run_addr0", rd_addr, 0);
    chk("t1_run_rst_n", rst_n_ctrl, 1);
    acc_done = 1'b1;
    fin = 1'b1;
    tick();
    acc_done = 1'b0;
    fin = 1'b0;
    chk("t1_run_addr1", rd_addr, 1);
    for (int i = 2; i < 4; i++) begin
      tick();
      chk("t1_run_addr", rd_addr, i);
    end
    tick();
    chk("t1_wait_addr_hold", rd_addr, 3);
    chk("t1_wait_en", en, 1);
    // T2: acc_done then finish two cycles later
    repeat (2) tick();
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    chk("t2_drain_en", en, 1);
    tick();
    ov_q.push_back(1'b0);
    fin = 1'b1;
    tick();
    fin = 1'b0;
    chk("t2_ov", out_valid, 1);
    chk("t2_release_en", en, 0);
    tick();
    chk("t2_ov_low", out_valid, 0);
    chk("t2_rd_bank", rd_bank, 1);
    tick();
    chk("t2_idle_en", en, 0);
    // T3/T4/T5: streaming with back-pressure over a full layer
    do_reset();
    first_stall = -1;
    total_sent = 0;
    fork
      send_beats(12);
      responder();
    join
    chk("t3_first_stall", first_stall, 8);
    chk("t3_overflow", overflow, 0);
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("t5_overflow", overflow, 0);
    chk("t5_done_sticky", done, 1);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_wr_q_empty", wr_q.size(), 0);
    // T6: reset in the middle of a read pass
    do_reset();
    send_beats(4);
    guard = 0;
    while (!(en && rd_addr == 2) && guard < 50) begin
      guard++;
      tick();
    end
    chk("t6_reached_run", int'(en && rd_addr == 2), 1);
    rst = 1'b1;
    tick();
    check_reset_outputs("t6");
    rst = 1'b0;
    m_bank = 0;
    m_addr = 0;
    repeat (10) tick();
    chk("t6_en_after", en, 0);
    chk("t6_in_ready_after", in_ready, 1);
    // T7: dropped beat sets sticky overflow
    send_beats(8);
    chk("t7_in_ready", in_ready, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t7_overflow", overflow, 1);
    tick();
    chk("t7_overflow_sticky", overflow, 1);
    chk("end_wr_q", wr_q.size(), 0);
    chk("end_ov_q", ov_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
